// File: rtl/div_unit.sv
// Iterative RV32M divide/remainder unit (DIV, DIVU, REM, REMU).
// Radix-2 restoring shift-subtract, one quotient bit per cycle, with write-back outputs.
module div_unit #(
  parameter int XLEN = 32,
  parameter int CW   = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic [4:0]      rd_addr,
  input  logic            kill,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out,
  output logic            we_out
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]      state;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] dvd;
  logic [XLEN-1:0] rem;
  logic [XLEN-1:0] dsr;
  logic            rem_sel;
  logic            neg_q;
  logic            neg_r;

  // Operand decode at accept time.
  logic            is_signed;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;
  logic            div_zero;
  logic            ovf;
  logic [XLEN-1:0] special_res;

  assign is_signed = ~op[0];
  assign a_neg     = is_signed & rs1_val[XLEN-1];
  assign b_neg     = is_signed & rs2_val[XLEN-1];
  assign a_mag     = a_neg ? -rs1_val : rs1_val;
  assign b_mag     = b_neg ? -rs2_val : rs2_val;
  assign div_zero  = (rs2_val == '0);
  assign ovf       = is_signed && (rs1_val == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_val == '1);

  // On overflow the quotient equals the dividend itself (most negative value).
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    special_res = '0;
    if (div_zero)  special_res = op[1] ? rs1_val : '1;
    else if (ovf)  special_res = op[1] ? '0 : rs1_val;
  end

  // One restoring iteration; the compare uses an XLEN+1 bit partial remainder.
  logic [XLEN:0]   rem_shift;
  logic [XLEN:0]   diff;
  logic            q_bit;
  logic [XLEN-1:0] rem_next;
  logic [XLEN-1:0] dvd_next;
  logic [XLEN-1:0] q_fix;
  logic [XLEN-1:0] r_fix;

  assign rem_shift = {rem, dvd[XLEN-1]};
  assign diff      = rem_shift - {1'b0, dsr};
  assign q_bit     = ~diff[XLEN];
  assign rem_next  = q_bit ? diff[XLEN-1:0] : rem_shift[XLEN-1:0];
  assign dvd_next  = {dvd[XLEN-2:0], q_bit};
  assign q_fix     = neg_q ? -dvd_next : dvd_next;
  assign r_fix     = neg_r ? -rem_next : rem_next;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      dvd     <= '0;
      rem     <= '0;
      dsr     <= '0;
      rem_sel <= 1'b0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      result  <= '0;
      rd_out  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      case (state)
        S_IDLE: begin
          if (start && !kill) begin
            rem_sel <= op[1];
            neg_q   <= a_neg ^ b_neg;
            neg_r   <= a_neg;
            rd_out  <= rd_addr;
            dvd     <= a_mag;
            dsr     <= b_mag;
            rem     <= '0;
            cnt     <= '0;
            if (div_zero || ovf) begin
              result <= special_res;
              state  <= S_DONE;
            end else begin
              state  <= S_CALC;
            end
          end
        end
        S_CALC: begin
          if (kill) begin
            state <= S_IDLE;
          end else begin
            dvd <= dvd_next;
            rem <= rem_next;
            cnt <= cnt + 1'b1;
            if (cnt == CW'(XLEN-1)) begin
              result <= rem_sel ? r_fix : q_fix;
              state  <= S_DONE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy   = (state == S_CALC);
  assign done   = (state == S_DONE) && !kill;
  assign we_out = done;

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit: normal ops, fast paths, kill, reset, held start.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic [4:0]  rd_addr;
  logic        kill;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [4:0]  rd_out;
  logic        we_out;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;

  div_unit #(.XLEN(32), .CW(6)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .rs1_val(rs1_val),
    .rs2_val(rs2_val), .rd_addr(rd_addr), .kill(kill), .busy(busy),
    .done(done), .result(result), .rd_out(rd_out), .we_out(we_out)
  );

  always #5 clk = ~clk;

  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] exp_res,
                       input int exp_lat, input string name);
    int   lat;
    int   busy_n;
    logic seen;
    @(negedge clk);
    op = o; rs1_val = a; rs2_val = b; rd_addr = rd; start = 1'b1;
    @(negedge clk);
    start = 1'b0; rs1_val = 32'hDEAD_BEEF; rs2_val = 32'h3; rd_addr = 5'h1F;
    lat = 1; busy_n = 0; seen = 1'b0;
    while (!seen && lat <= 40) begin
      if (done) seen = 1'b1;
      else begin
        if (busy) busy_n++;
        @(negedge clk);
        lat++;
      end
    end
    chk_cnt++;
    if (!seen) $display("FAIL %s timeout: no done within 40 cycles", name);
    else if (lat !== exp_lat) $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat);
    else pass_cnt++;
    chk_cnt++;
    if (result !== exp_res) $display("FAIL %s result: got %h want %h", name, result, exp_res);
    else pass_cnt++;
    chk_cnt++;
    if (rd_out !== rd || we_out !== 1'b1)
      $display("FAIL %s wb: rd_out=%0d we_out=%b want rd=%0d we=1", name, rd_out, we_out, rd);
    else pass_cnt++;
    chk_cnt++;
    if (busy_n !== exp_lat - 1) $display("FAIL %s busy cycles: got %0d want %0d", name, busy_n, exp_lat - 1);
    else pass_cnt++;
    @(negedge clk);
    chk_cnt++;
    if (done !== 1'b0) $display("FAIL %s pulse: done=%b want 0 one cycle later", name, done);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; kill = 1'b0; op = 2'b00;
    rs1_val = '0; rs2_val = '0; rd_addr = '0;
    #3;
    chk_cnt++;
    if (busy !== 1'b0 || done !== 1'b0 || we_out !== 1'b0 || result !== 32'h0 || rd_out !== 5'h0)
      $display("FAIL reset: busy=%b done=%b we=%b result=%h rd=%0d want all 0",
               busy, done, we_out, result, rd_out);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_unsigned();
    do_op(OP_DIVU, 32'd100, 32'd7, 5'd3, 32'h0000_000E, 33, "divu_100_7");
    do_op(OP_REMU, 32'd100, 32'd7, 5'd4, 32'h0000_0002, 33, "remu_100_7");
    do_op(OP_DIVU, 32'hFFFF_FFFF, 32'd1, 5'd5, 32'hFFFF_FFFF, 33, "divu_max_1");
  endtask

  task automatic test_signed();
    do_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFD, 33, "div_m7_2");
    do_op(OP_REM, 32'hFFFF_FFF9, 32'd2, 5'd7, 32'hFFFF_FFFF, 33, "rem_m7_2");
    do_op(OP_REM, 32'd7, 32'hFFFF_FFFE, 5'd8, 32'h0000_0001, 33, "rem_7_m2");
  endtask

  task automatic test_special();
    do_op(OP_DIV,  32'd5, 32'd0, 5'd9,  32'hFFFF_FFFF, 1, "div_5_0");
    do_op(OP_REMU, 32'd5, 32'd0, 5'd10, 32'h0000_0005, 1, "remu_5_0");
    do_op(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h8000_0000, 1, "div_ovf");
    do_op(OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'h0000_0000, 1, "rem_ovf");
  endtask

  task automatic test_kill();
    // Kill mid-CALC.
    @(negedge clk);
    op = OP_DIVU; rs1_val = 32'd1000; rs2_val = 32'd3; rd_addr = 5'd13; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    chk_cnt++;
    if (busy !== 1'b0 || done !== 1'b0)
      $display("FAIL kill_calc: busy=%b done=%b want 0 0", busy, done);
    else pass_cnt++;
    do_op(OP_DIVU, 32'd1000, 32'd3, 5'd14, 32'd333, 33, "after_kill");
    // Kill while in DONE masks the write-back.
    @(negedge clk);
    op = OP_DIVU; rs1_val = 32'd6; rs2_val = 32'd0; rd_addr = 5'd15; start = 1'b1;
    @(negedge clk);
    start = 1'b0; kill = 1'b1;
    #1;
    chk_cnt++;
    if (done !== 1'b0 || we_out !== 1'b0)
      $display("FAIL kill_done: done=%b we=%b want 0 0", done, we_out);
    else pass_cnt++;
    // Kill has priority over start in IDLE.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0; kill = 1'b0;
    chk_cnt++;
    if (busy !== 1'b0 || done !== 1'b0)
      $display("FAIL kill_idle: busy=%b done=%b want 0 0", busy, done);
    else pass_cnt++;
  endtask

  task automatic test_async_reset();
    int dones;
    @(negedge clk);
    op = OP_DIVU; rs1_val = 32'd100; rs2_val = 32'd7; rd_addr = 5'd16; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk_cnt++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0 || rd_out !== 5'h0)
      $display("FAIL async_reset: busy=%b done=%b result=%h rd=%0d want 0", busy, done, result, rd_out);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b1;
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) dones++;
    end
    chk_cnt++;
    if (dones !== 0) $display("FAIL reset_discard: done pulses=%0d want 0", dones);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int dones;
    int busy_n;
    @(negedge clk);
    op = OP_DIVU; rs1_val = 32'd100; rs2_val = 32'd7; rd_addr = 5'd17; start = 1'b1;
    dones = 0; busy_n = 0;
    for (int n = 1; n <= 68; n++) begin
      @(negedge clk);
      if (done) dones++;
      if (busy) busy_n++;
    end
    start = 1'b0;
    chk_cnt++;
    if (dones !== 2) $display("FAIL held_start dones: got %0d want 2", dones);
    else pass_cnt++;
    chk_cnt++;
    if (busy_n !== 64) $display("FAIL held_start busy: got %0d want 64", busy_n);
    else pass_cnt++;
    chk_cnt++;
    if (result !== 32'h0000_000E) $display("FAIL held_start result: got %h want 0000000e", result);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_special();
    test_kill();
    test_async_reset();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Iterative RV32M divide/remainder unit (DIV, DIVU, REM, REMU) directly downstream of the register file.
- Consumes RD1/RD2 operand values and produces a write-back value plus destination address for the WD3/A3 write port.
- Radix-2 restoring shift-subtract, one quotient bit per cycle; `busy` stalls the core while an operation is in flight.

Parameters:
XLEN, 32, operand/result width; iteration count equals XLEN.
CW, 6, iteration counter width; must satisfy 2^CW > XLEN.

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
op  input  2  00=DIV, 01=DIVU, 10=REM, 11=REMU
rs1_val  input  XLEN  dividend (from RD1)
rs2_val  input  XLEN  divisor (from RD2)
rd_addr  input  5  destination register
kill  input  1  synchronous abort (pipeline flush)
busy  output  1  high while state==CALC
done  output  1  one-cycle pulse; result/rd_out valid
result  output  XLEN  quotient or remainder
rd_out  output  5  destination for write-back (to A3)
we_out  output  1  equals done; drives WE3

Behaviour:
- Reset (`rst`=0, asynchronous):
  - state=IDLE.
  - busy=0, done=0, we_out=0, result=0, rd_out=0.
  - Internal registers cleared.
  - Reset mid-operation discards all work; no `done` is produced.
- States: IDLE, CALC, DONE.
- Transitions out of IDLE:
  - start=1 and kill=0 at edge k: latch op, rd_addr, operand magnitudes and sign info.
  - Normal case: go to CALC, counter=0.
  - Fast path (divisor==0, or signed overflow): go directly to DONE at edge k with the special result loaded.
  - start=0: stay in IDLE.
- CALC iteration, one per edge:
  - rem = {rem[XLEN-2:0], dvd[XLEN-1]}; dvd <<= 1.
  - If rem >= divisor: rem -= divisor and shift in quotient bit 1; else shift in 0.
  - Counter increments each edge.
  - After the XLEN-th iteration (edge k+32): apply sign fixup, load `result`, go to DONE.
- Sign fixup (signed ops only):
  - Quotient is negated when sign(rs1) != sign(rs2).
  - Remainder takes the sign of rs1.
  - Operands are converted to magnitudes (two's-complement negate) at accept.
- DONE state:
  - done=1 and we_out=1 for exactly one cycle.
  - Next edge: go to IDLE unconditionally.
  - A `start` asserted while in DONE is ignored; it must be re-presented in IDLE.
- Latency: normal case, done is high in the cycle after edge k+32 (33 cycles from accept); fast path, the cycle after edge k (1 cycle).
- Special results (RISC-V spec):
  - Divide by zero: quotient = all ones (both signed and unsigned); remainder = rs1.
  - Signed overflow (rs1=0x80000000, rs2=0xFFFFFFFF, op DIV/REM): quotient = 0x80000000, remainder = 0.
- kill:
  - Asserted in CALC or DONE: next edge goes to IDLE; done/we_out are forced 0 in that cycle and the result is not written back.
  - kill has priority over start in IDLE.
- Output holding: `result` and `rd_out` hold their last values after DONE until the next accepted operation loads new ones; consumers must qualify them with `done`.
- Operands are sampled only at accept; rs1_val/rs2_val may change during CALC without effect.
- Width rules: remainder register is XLEN+1 bits for the compare/subtract; all arithmetic is modulo 2^XLEN at the output.

Test Plan:
- DIVU 100/7: start in IDLE → busy for 32 cycles, done pulse at cycle 33, result=14 (0x0E), rd_out=rd_addr; repeat with REMU → result=2.
- DIV 0xFFFFFFF9 (-7) / 2 → result 0xFFFFFFFD (-3); REM same operands → 0xFFFFFFFF (-1); REM 7 / -2 → 1.
- Divide by zero: DIV 5/0 → done after 1 cycle, result=0xFFFFFFFF, busy never high; REMU 5/0 → result=5.
- Overflow: DIV 0x80000000/0xFFFFFFFF → result 0x80000000 in 1 cycle; REM same operands → 0.
- Abort/reset: kill at iteration 10 → IDLE next edge, no done, new start accepted immediately and completes correctly; rst=0 mid-CALC → busy/done/result=0 immediately (asynchronous); start held high during CALC/DONE → exactly one operation per IDLE acceptance.
